// File: rtl/ibex_regfile_wr_arbiter.sv
// ibex_regfile_wr_arbiter: init sweep of the FPGA register file, then fixed-priority EX/LSU
// sharing of its single write port with EX anti-starvation; all rf_* outputs registered.
module ibex_regfile_wr_arbiter #(
    parameter bit                   RV32E     = 1'b0,
    parameter int unsigned          DataWidth = 32,
    parameter logic [DataWidth-1:0] InitVal   = '0,
    parameter int unsigned          MaxWait   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 ex_req_i,
    input  logic [4:0]           ex_addr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 ex_gnt_o,
    input  logic                 lsu_req_i,
    input  logic [4:0]           lsu_addr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 lsu_gnt_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 init_done_o,
    output logic                 err_o
);
    localparam logic [4:0] LastReg = RV32E ? 5'd15 : 5'd31;
    localparam logic [3:0] WaitMax = 4'(MaxWait);

    typedef enum logic {INIT, RUN} state_e;

    state_e               state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [3:0]           wait_q, wait_d;
    logic                 we_q, we_d;
    logic                 err_q, err_d;
    logic [4:0]           waddr_q, waddr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 run, ex_prio, gnt_any, addr_bad;
    logic [4:0]           gnt_addr;
    logic [DataWidth-1:0] gnt_wdata;

    assign run       = state_q == RUN;
    assign ex_prio   = wait_q == WaitMax;
    assign lsu_gnt_o = run & lsu_req_i & ~(ex_req_i & ex_prio);
    assign ex_gnt_o  = run & ex_req_i & (~lsu_req_i | ex_prio);
    assign gnt_any   = ex_gnt_o | lsu_gnt_o;
    assign gnt_addr  = ex_gnt_o ? ex_addr_i : lsu_addr_i;
    assign gnt_wdata = ex_gnt_o ? ex_wdata_i : lsu_wdata_i;
    assign addr_bad  = RV32E & gnt_addr[4];

    // A write granted in a flush cycle still commits; flush only redirects the state and counters.
    always_comb begin
        state_d = flush_i ? INIT : (run || cnt_q == LastReg) ? RUN : INIT;
        cnt_d   = (flush_i || run) ? 5'd1 : cnt_q + 5'd1;
        wait_d  = (!run || flush_i || !ex_req_i || ex_gnt_o) ? 4'd0 : ex_prio ? wait_q : wait_q + 4'd1;
        we_d    = run ? gnt_any & (gnt_addr != 5'd0) & ~addr_bad : 1'b1;
        waddr_d = run ? (gnt_any ? gnt_addr : waddr_q) : cnt_q;
        wdata_d = run ? (gnt_any ? gnt_wdata : wdata_q) : InitVal;
        err_d   = err_q | (gnt_any & addr_bad);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= INIT;
            cnt_q   <= 5'd1;
            wait_q  <= 4'd0;
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign rf_we_o     = we_q;
    assign rf_waddr_o  = waddr_q;
    assign rf_wdata_o  = wdata_q;
    assign init_done_o = run;
    assign err_o       = err_q;
endmodule

// File: tb/tb_ibex_regfile_wr_arbiter.sv
// tb_ibex_regfile_wr_arbiter: directed scoreboard bench for an RV32I and an RV32E instance.
module tb_ibex_regfile_wr_arbiter;
    localparam logic [31:0] Init0 = 32'h1234_5678;
    localparam logic [31:0] Init1 = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush0, ex_req0, ex_gnt0, lsu_req0, lsu_gnt0, rf_we0, done0, err0;
    logic [4:0]  ex_addr0, lsu_addr0, rf_waddr0;
    logic [31:0] ex_wdata0, lsu_wdata0, rf_wdata0;
    logic        flush1, ex_req1, ex_gnt1, lsu_req1, lsu_gnt1, rf_we1, done1, err1;
    logic [4:0]  ex_addr1, lsu_addr1, rf_waddr1;
    logic [31:0] ex_wdata1, lsu_wdata1, rf_wdata1;
    logic [36:0] q0[$];
    logic [36:0] q1[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    ibex_regfile_wr_arbiter #(.RV32E(1'b0), .DataWidth(32), .InitVal(Init0), .MaxWait(4)) dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush0),
        .ex_req_i(ex_req0), .ex_addr_i(ex_addr0), .ex_wdata_i(ex_wdata0), .ex_gnt_o(ex_gnt0),
        .lsu_req_i(lsu_req0), .lsu_addr_i(lsu_addr0), .lsu_wdata_i(lsu_wdata0), .lsu_gnt_o(lsu_gnt0),
        .rf_we_o(rf_we0), .rf_waddr_o(rf_waddr0), .rf_wdata_o(rf_wdata0),
        .init_done_o(done0), .err_o(err0)
    );

    ibex_regfile_wr_arbiter #(.RV32E(1'b1), .DataWidth(32), .InitVal(Init1), .MaxWait(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush1),
        .ex_req_i(ex_req1), .ex_addr_i(ex_addr1), .ex_wdata_i(ex_wdata1), .ex_gnt_o(ex_gnt1),
        .lsu_req_i(lsu_req1), .lsu_addr_i(lsu_addr1), .lsu_wdata_i(lsu_wdata1), .lsu_gnt_o(lsu_gnt1),
        .rf_we_o(rf_we1), .rf_waddr_o(rf_waddr1), .rf_wdata_o(rf_wdata1),
        .init_done_o(done1), .err_o(err1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push_sweeps();
        for (int a = 1; a < 32; a++) q0.push_back({5'(a), Init0});
        for (int a = 1; a < 16; a++) q1.push_back({5'(a), Init1});
    endtask

    // Every committed write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rf_we0) begin
            if (q0.size() != 0) chk("wr0", 64'({rf_waddr0, rf_wdata0}), 64'(q0.pop_front()));
            else chk("wr0_unexpected", 64'(rf_we0), 64'(1'b0));
        end
        if (rf_we1) begin
            if (q1.size() != 0) chk("wr1", 64'({rf_waddr1, rf_wdata1}), 64'(q1.pop_front()));
            else chk("wr1_unexpected", 64'(rf_we1), 64'(1'b0));
        end
    end

    initial begin
        {flush0, ex_req0, lsu_req0, flush1, ex_req1, lsu_req1} = '0;
        {ex_addr0, lsu_addr0, ex_addr1, lsu_addr1} = '0;
        {ex_wdata0, lsu_wdata0, ex_wdata1, lsu_wdata1} = '0;
        repeat (2) nxt();
        smp();
        chk("rst_we0", 64'(rf_we0), 64'(1'b0));
        chk("rst_waddr0", 64'(rf_waddr0), 64'(5'd0));
        chk("rst_wdata0", 64'(rf_wdata0), 64'(32'd0));
        nxt();
        rst = 1'b0;
        push_sweeps();
        ex_req0 = 1'b1;
        lsu_req0 = 1'b1;
        smp();
        chk("rel_we0", 64'(rf_we0), 64'(1'b0));
        chk("rel_done0", 64'(done0), 64'(1'b0));
        chk("rel_err0", 64'(err0), 64'(1'b0));
        chk("init_ex_gnt", 64'(ex_gnt0), 64'(1'b0));
        chk("init_lsu_gnt", 64'(lsu_gnt0), 64'(1'b0));
        for (int i = 0; i < 31; i++) begin
            nxt();
            if (i == 1) begin ex_req0 = 1'b0; lsu_req0 = 1'b0; end
            smp();
            if (i == 0) begin
                chk("sweep_ex_gnt", 64'(ex_gnt0), 64'(1'b0));
                chk("sweep_lsu_gnt", 64'(lsu_gnt0), 64'(1'b0));
            end
            chk("sweep_done0", 64'(done0), 64'(i == 30));
            chk("sweep_done1", 64'(done1), 64'(i >= 14));
        end
        nxt();
        smp();
        chk("post_sweep_we0", 64'(rf_we0), 64'(1'b0));
        chk("post_sweep_done0", 64'(done0), 64'(1'b1));

        nxt();
        ex_req0 = 1'b1; ex_addr0 = 5'd5; ex_wdata0 = 32'hAAAA;
        lsu_req0 = 1'b1; lsu_addr0 = 5'd6; lsu_wdata0 = 32'h5555;
        smp();
        chk("both_lsu_gnt", 64'(lsu_gnt0), 64'(1'b1));
        chk("both_ex_gnt", 64'(ex_gnt0), 64'(1'b0));
        q0.push_back({5'd6, 32'h5555});
        nxt();
        lsu_req0 = 1'b0;
        smp();
        chk("retry_ex_gnt", 64'(ex_gnt0), 64'(1'b1));
        chk("retry_lsu_gnt", 64'(lsu_gnt0), 64'(1'b0));
        chk("x6_we", 64'(rf_we0), 64'(1'b1));
        q0.push_back({5'd5, 32'hAAAA});
        nxt();
        ex_req0 = 1'b0;
        smp();

        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 5; k++) begin
                nxt();
                ex_req0 = 1'b1; ex_addr0 = 5'(7 + r); ex_wdata0 = 32'h7000 + 32'(r);
                lsu_req0 = 1'b1; lsu_addr0 = 5'(10 + k); lsu_wdata0 = 32'(100 * r + k);
                smp();
                if (k < 4) begin
                    chk("starve_ex_gnt", 64'(ex_gnt0), 64'(1'b0));
                    chk("starve_lsu_gnt", 64'(lsu_gnt0), 64'(1'b1));
                    q0.push_back({lsu_addr0, lsu_wdata0});
                end else begin
                    chk("prio_ex_gnt", 64'(ex_gnt0), 64'(1'b1));
                    chk("prio_lsu_gnt", 64'(lsu_gnt0), 64'(1'b0));
                    q0.push_back({ex_addr0, ex_wdata0});
                end
            end
        end

        nxt();
        lsu_req0 = 1'b0;
        ex_req0 = 1'b1; ex_addr0 = 5'd0; ex_wdata0 = 32'hFFFF;
        smp();
        chk("x0_gnt", 64'(ex_gnt0), 64'(1'b1));
        nxt();
        ex_req0 = 1'b0;
        smp();
        chk("x0_we", 64'(rf_we0), 64'(1'b0));
        chk("x0_err", 64'(err0), 64'(1'b0));

        nxt();
        ex_req0 = 1'b1; ex_addr0 = 5'd9; ex_wdata0 = 32'h9999; flush0 = 1'b1;
        smp();
        chk("flush_ex_gnt", 64'(ex_gnt0), 64'(1'b1));
        q0.push_back({5'd9, 32'h9999});
        for (int a = 1; a < 32; a++) q0.push_back({5'(a), Init0});
        nxt();
        flush0 = 1'b0; ex_addr0 = 5'd3; lsu_req0 = 1'b1;
        smp();
        chk("flush_x9_we", 64'(rf_we0), 64'(1'b1));
        chk("flush_gnt_ex", 64'(ex_gnt0), 64'(1'b0));
        chk("flush_gnt_lsu", 64'(lsu_gnt0), 64'(1'b0));
        chk("flush_done", 64'(done0), 64'(1'b0));
        for (int i = 0; i < 31; i++) begin
            nxt();
            if (i == 1) begin ex_req0 = 1'b0; lsu_req0 = 1'b0; end
            smp();
            if (i == 0) chk("resweep_ex_gnt", 64'(ex_gnt0), 64'(1'b0));
            chk("resweep_done", 64'(done0), 64'(i == 30));
        end

        nxt();
        flush0 = 1'b1;
        q0.push_back({5'd1, Init0});
        q0.push_back({5'd1, Init0});
        for (int a = 1; a < 32; a++) q0.push_back({5'(a), Init0});
        nxt();
        smp();
        chk("hold_flush_done", 64'(done0), 64'(1'b0));
        nxt();
        nxt();
        flush0 = 1'b0;
        for (int i = 0; i < 40 && !done0; i++) begin
            nxt();
            smp();
        end
        chk("hold_flush_end_done", 64'(done0), 64'(1'b1));
        nxt();
        smp();
        chk("q0_drained", 64'(q0.size()), 64'(0));

        nxt();
        lsu_req1 = 1'b1; lsu_addr1 = 5'd20; lsu_wdata1 = 32'h2020;
        smp();
        chk("e_lsu_gnt", 64'(lsu_gnt1), 64'(1'b1));
        nxt();
        lsu_req1 = 1'b0;
        ex_req1 = 1'b1; ex_addr1 = 5'd3; ex_wdata1 = 32'h3333;
        smp();
        chk("e_x20_we", 64'(rf_we1), 64'(1'b0));
        chk("e_x20_err", 64'(err1), 64'(1'b1));
        chk("e_ex_gnt", 64'(ex_gnt1), 64'(1'b1));
        q1.push_back({5'd3, 32'h3333});
        nxt();
        ex_req1 = 1'b0; flush1 = 1'b1;
        smp();
        for (int a = 1; a < 16; a++) q1.push_back({5'(a), Init1});
        nxt();
        flush1 = 1'b0;
        smp();
        chk("e_flush_err", 64'(err1), 64'(1'b1));
        repeat (5) nxt();

        rst = 1'b1;
        #1;
        chk("arst_we1", 64'(rf_we1), 64'(1'b0));
        chk("arst_waddr1", 64'(rf_waddr1), 64'(5'd0));
        chk("arst_err1", 64'(err1), 64'(1'b0));
        chk("arst_done0", 64'(done0), 64'(1'b0));
        q0.delete();
        q1.delete();
        nxt();
        rst = 1'b0;
        push_sweeps();
        for (int i = 0; i < 31; i++) begin
            nxt();
            smp();
        end
        nxt();
        smp();
        chk("final_done0", 64'(done0), 64'(1'b1));
        chk("final_done1", 64'(done1), 64'(1'b1));
        chk("final_q0", 64'(q0.size()), 64'(0));
        chk("final_q1", 64'(q1.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
